// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, flag bit positions and word types for the
// half-precision FP units and the buffering around them.
package fpu_pkg;

  localparam int EXP_W  = 5;
  localparam int FRA_W  = 10;
  localparam int WORD_W = EXP_W + FRA_W + 1;

  localparam int FLAG_W    = 3;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;

  typedef logic [WORD_W-1:0] fp_word_t;
  typedef logic [FLAG_W-1:0] fp_flags_t;

endpackage

// File: rtl/fpu_credit_ctr.sv
// fpu_credit_ctr: tracks operands launched into the FP unit whose results
// have not come back yet, and grants a new launch only when a buffer slot
// is guaranteed for its result. Also flags launches attempted without credit.
module fpu_credit_ctr
  import fpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          i_issueFire,
  input  logic          i_resultValid,
  input  logic [CW-1:0] i_occNext,
  output logic          o_issueReady,
  output logic          o_inflightZero,
  output logic          o_overrunErr
);

  logic [CW-1:0] r_inflight;
  logic          r_issueReady;
  logic          r_overrunErr;
  logic [CW-1:0] w_inflightNext;
  logic [CW:0]   w_committed;
  logic          w_issueAccept;
  logic          w_resultRetire;

  assign w_issueAccept  = i_issueFire & r_issueReady;
  assign w_resultRetire = i_resultValid & (r_inflight != '0);

  // Next in-flight count; a launch and a retiring result in the same cycle cancel out
  always_comb begin
    w_inflightNext = r_inflight;
    if (w_issueAccept && !w_resultRetire) begin
      w_inflightNext = r_inflight + CW'(1);
    end else if (!w_issueAccept && w_resultRetire) begin
      w_inflightNext = r_inflight - CW'(1);
    end
  end

  assign w_committed = {1'b0, i_occNext} + {1'b0, w_inflightNext};

  // Register the count and the credit flag, which is derived from next-state counters
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_inflight   <= '0;
      r_issueReady <= 1'b0;
      r_overrunErr <= 1'b0;
    end else begin
      r_inflight   <= w_inflightNext;
      r_issueReady <= (w_committed < (CW + 1)'(DEPTH));
      if (i_issueFire && !r_issueReady) begin
        r_overrunErr <= 1'b1;
      end
    end
  end

  assign o_issueReady   = r_issueReady;
  assign o_inflightZero = (r_inflight == '0);
  assign o_overrunErr   = r_overrunErr;

endmodule

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: captures every result of a fixed-latency FP unit (which
// cannot be back-pressured) and re-presents it on a valid/ready stream.
// Launch credits come from fpu_credit_ctr so a slot is always reserved.
// Optional flag storage is enabled by defining FPU_RESULT_FIFO_FLAG_EN.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int EXP   = EXP_W,
  parameter int FRA   = FRA_W,
  parameter int DEPTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     issue_fire,
  output logic                     issue_ready,
  input  logic [EXP+FRA:0]         s_axis_result_tdata,
  input  logic                     s_axis_result_tvalid,
  input  logic [FLAG_W-1:0]        s_flag,
  output logic [EXP+FRA:0]         m_axis_tdata,
  output logic [FLAG_W-1:0]        m_axis_tflag,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               err
);

  localparam int W  = EXP + FRA + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_data [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_occ;
  logic          r_unexpErr;
  logic [CW-1:0] w_occNext;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_inflightZero;
  logic          w_overrunErr;

  assign w_full        = (r_occ == CW'(DEPTH));
  assign m_axis_tvalid = (r_occ != '0);
  assign w_rd          = m_axis_tvalid & m_axis_tready;
  assign w_wr          = s_axis_result_tvalid & (~w_full | w_rd);

  // Next occupancy; a same-cycle read and write leave it unchanged, even when full
  always_comb begin
    w_occNext = r_occ;
    if (w_wr && !w_rd) begin
      w_occNext = r_occ + CW'(1);
    end else if (!w_wr && w_rd) begin
      w_occNext = r_occ - CW'(1);
    end
  end

  fpu_credit_ctr #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_creditCtr (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .i_issueFire   (issue_fire),
    .i_resultValid (s_axis_result_tvalid),
    .i_occNext     (w_occNext),
    .o_issueReady  (issue_ready),
    .o_inflightZero(w_inflightZero),
    .o_overrunErr  (w_overrunErr)
  );

  // Word storage, cleared on reset so the head reads zero until the first write
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else if (w_wr) begin
      r_data[r_wrPtr] <= s_axis_result_tdata;
    end
  end

  // Pointers, occupancy and the sticky unexpected/dropped-result error
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_occ      <= '0;
      r_unexpErr <= 1'b0;
    end else begin
      r_occ <= w_occNext;
      if (w_wr) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_rd) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (s_axis_result_tvalid && (w_inflightZero || !w_wr)) begin
        r_unexpErr <= 1'b1;
      end
    end
  end

  assign m_axis_tdata = r_data[r_rdPtr];
  assign occupancy    = r_occ;
  assign err          = {r_unexpErr, w_overrunErr};

`ifdef FPU_RESULT_FIFO_FLAG_EN
  logic [FLAG_W-1:0] r_flag [DEPTH];

  // Flag storage, written alongside each data word
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_flag[i] <= '0;
      end
    end else if (w_wr) begin
      r_flag[r_wrPtr] <= s_flag;
    end
  end

  assign m_axis_tflag = r_flag[r_rdPtr];
`else
  logic [FLAG_W-1:0] w_unusedFlag;

  assign w_unusedFlag = s_flag;
  assign m_axis_tflag = '0;
`endif

endmodule

// File: tb/tb_fpu_result_fifo.sv
// tb_fpu_result_fifo: directed bench with a scoreboard queue; stimulus pushes
// expected words and a forked monitor pops them on every consumer handshake.
`timescale 1ns/1ps
module tb_fpu_result_fifo;
  import fpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    fp_word_t  data;
    fp_flags_t flag;
  } exp_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          issue_fire;
  logic          issue_ready;
  fp_word_t      s_tdata;
  logic          s_tvalid;
  fp_flags_t     s_flag;
  fp_word_t      m_tdata;
  fp_flags_t     m_tflag;
  logic          m_tvalid;
  logic          m_tready;
  logic [CW-1:0] occupancy;
  logic [1:0]    err;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t expQ[$];

  fpu_result_fifo #(
    .EXP  (EXP_W),
    .FRA  (FRA_W),
    .DEPTH(DEPTH)
  ) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .issue_fire          (issue_fire),
    .issue_ready         (issue_ready),
    .s_axis_result_tdata (s_tdata),
    .s_axis_result_tvalid(s_tvalid),
    .s_flag              (s_flag),
    .m_axis_tdata        (m_tdata),
    .m_axis_tflag        (m_tflag),
    .m_axis_tvalid       (m_tvalid),
    .m_axis_tready       (m_tready),
    .occupancy           (occupancy),
    .err                 (err)
  );

  // Free-running clock
  always #5 aclk = ~aclk;

  // Flags only survive the buffer when flag storage is built in
  function automatic fp_flags_t expFlag(input fp_flags_t f);
`ifdef FPU_RESULT_FIFO_FLAG_EN
    return f;
`else
    return f & 3'b000;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, optionally record the word as an expected output
  task automatic applyStimulus(input logic fire, input logic rv, input fp_word_t word,
                               input fp_flags_t flag, input logic ready, input logic expectOut);
    exp_t e;
    issue_fire = fire;
    s_tvalid   = rv;
    s_tdata    = word;
    s_flag     = flag;
    m_tready   = ready;
    if (expectOut) begin
      e.data = word;
      e.flag = expFlag(flag);
      expQ.push_back(e);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 1'b0, '0, '0, ready, 1'b0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int        issued;
    int        delivered;
    logic [2:0] pipe;
    logic      fire;

    // Scoreboard monitor: compare every word the consumer accepts
    fork
      forever begin
        exp_t e;
        @(negedge aclk);
        if (!aresetn && m_tvalid && m_tready) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL extraRead: got 0x%0h, expected no output", m_tdata);
          end else begin
            e = expQ.pop_front();
            checkOutput("readData", 32'(m_tdata), 32'(e.data));
            checkOutput("readFlag", 32'(m_tflag), 32'(e.flag));
          end
        end
      end
    join_none

    // Reset values
    aresetn = 1'b1;
    issue_fire = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_flag = '0; m_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rstIssueReady", 32'(issue_ready), 32'd0);
    checkOutput("rstTvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rstTdata", 32'(m_tdata), 32'd0);
    checkOutput("rstTflag", 32'(m_tflag), 32'd0);
    checkOutput("rstOcc", 32'(occupancy), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    aresetn = 1'b0;
    idle(1'b0);
    checkOutput("readyAfterRelease", 32'(issue_ready), 32'd1);

    // Fill the credit pool with 8 back-to-back launches, then overrun
    for (int i = 0; i < 8; i++) begin
      if (i == 7) checkOutput("readyBefore8th", 32'(issue_ready), 32'd1);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    checkOutput("readyAfter8th", 32'(issue_ready), 32'd0);
    checkOutput("errBeforeOverrun", 32'(err), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("errOverrun", 32'(err), 32'b01);
    checkOutput("readyStillLow", 32'(issue_ready), 32'd0);

    // Stall with ordering
    checkOutput("tvalidBeforeResult", 32'(m_tvalid), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h3C00, '0, 1'b0, 1'b1);
    checkOutput("tvalidOneCycle", 32'(m_tvalid), 32'd1);
    checkOutput("headFirst", 32'(m_tdata), 32'h3C00);
    applyStimulus(1'b0, 1'b1, 16'h4000, '0, 1'b0, 1'b1);
    checkOutput("headHeld", 32'(m_tdata), 32'h3C00);
    checkOutput("occTwo", 32'(occupancy), 32'd2);
    idle(1'b0);
    checkOutput("headHeldStall", 32'(m_tdata), 32'h3C00);
    idle(1'b1);
    checkOutput("creditAfterRead", 32'(issue_ready), 32'd1);
    idle(1'b1);
    checkOutput("tvalidDrained", 32'(m_tvalid), 32'd0);
    checkOutput("occDrained", 32'(occupancy), 32'd0);

    // Full buffer: six outstanding results, two more launches, two more results
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, fp_word_t'(16'h4200 + i), '0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h4206, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h4207, '0, 1'b0, 1'b1);
    checkOutput("occFull", 32'(occupancy), 32'd8);
    checkOutput("errFullNoNew", 32'(err), 32'b01);
    checkOutput("readyFull", 32'(issue_ready), 32'd0);
    checkOutput("headFull", 32'(m_tdata), 32'h4200);
    // Full with no read: word dropped (nothing in flight either, so err[1])
    applyStimulus(1'b0, 1'b1, 16'hDEAD, '0, 1'b0, 1'b0);
    checkOutput("occAfterDrop", 32'(occupancy), 32'd8);
    checkOutput("errAfterDrop", 32'(err), 32'b11);
    // Full with concurrent read: new word accepted and queued last
    applyStimulus(1'b0, 1'b1, 16'h7BFF, fp_flags_t'(1 << FLAG_NAN), 1'b1, 1'b1);
    checkOutput("occFullRw", 32'(occupancy), 32'd8);
    s_tvalid = 1'b0;
    for (int c = 0; c < 20 && occupancy != '0; c++) idle(1'b1);
    checkOutput("occAfterDrain", 32'(occupancy), 32'd0);
    checkOutput("scoreboardEmpty1", 32'(expQ.size()), 32'd0);

    // Reset mid-operation discards contents and in-flight accounting
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1111, '0, 1'b0, 1'b0);
    aresetn = 1'b1;
    idle(1'b0);
    idle(1'b0);
    checkOutput("midRstOcc", 32'(occupancy), 32'd0);
    checkOutput("midRstErr", 32'(err), 32'd0);
    checkOutput("midRstTvalid", 32'(m_tvalid), 32'd0);
    checkOutput("midRstTdata", 32'(m_tdata), 32'd0);

    // Unexpected result in the first cycle after release, carrying a NaN flag
    aresetn = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h1234, 3'b100, 1'b0, 1'b1);
    checkOutput("unexpOcc", 32'(occupancy), 32'd1);
    checkOutput("unexpErr", 32'(err), 32'b10);
    checkOutput("unexpData", 32'(m_tdata), 32'h1234);
    checkOutput("flagPass", 32'(m_tflag), 32'(expFlag(3'b100)));
    idle(1'b1);
    checkOutput("unexpDrained", 32'(occupancy), 32'd0);

    // Clean slate for streaming
    aresetn = 1'b1;
    idle(1'b0);
    aresetn = 1'b0;
    idle(1'b0);
    checkOutput("errCleared", 32'(err), 32'd0);

    // Wrap-around: 20 results through a 3-cycle model unit, paced by credits
    issued = 0;
    delivered = 0;
    pipe = '0;
    for (int c = 0; c < 200 && delivered < 20; c++) begin
      fire = (issued < 20) && issue_ready;
      applyStimulus(fire, pipe[2], fp_word_t'(16'h0100 + delivered),
                    fp_flags_t'(delivered), 1'b1, pipe[2]);
      if (fire) issued++;
      if (pipe[2]) delivered++;
      pipe = {pipe[1:0], fire};
    end
    issue_fire = 1'b0;
    s_tvalid = 1'b0;
    for (int c = 0; c < 20 && occupancy != '0; c++) idle(1'b1);
    checkOutput("wrapDelivered", 32'(delivered), 32'd20);
    checkOutput("wrapOcc", 32'(occupancy), 32'd0);
    checkOutput("wrapErr", 32'(err), 32'd0);
    idle(1'b0);
    checkOutput("scoreboardEmpty2", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fpu_result_fifo.md
# fpu_result_fifo

Credit-managed result buffer for the fixed-latency half-precision arithmetic units (divide, multiply, add) whose result stream has no `tready`. It captures every result the unit emits and re-presents it on a full valid/ready stream toward the consumer. It issues operand credits so the unit is never launched unless a buffer slot is guaranteed for its result. It sits between the FP unit's result port and the downstream consumer, with its credit output gating the operand issuer.

## Interface

**Parameters**
- `EXP`, default 5: exponent width.
- `FRA`, default 10: fraction width. Data words are `EXP+FRA+1` bits.
- `DEPTH`, default 8: buffer entries. Power of two, minimum 2.

**Ports**

Clock and reset:
- `aclk`, in, 1: the single clock.
- `aresetn`, in, 1: asynchronous, active-high reset (the name is kept for consistency with the rest of the codebase).

Issue side:
- `issue_fire`, in, 1: operand pair launched into the FP unit this cycle.
- `issue_ready`, out, 1: a credit is available, so launching is permitted.

Result side, from the FP unit:
- `s_axis_result_tdata`, in, `EXP+FRA+1`: result word.
- `s_axis_result_tvalid`, in, 1: result valid. There is no ready signal on this side.
- `s_flag`, in, 3: zero/inf/NaN flags accompanying the result.

Consumer side:
- `m_axis_tdata`, out, `EXP+FRA+1`: buffered result.
- `m_axis_tflag`, out, 3: buffered flags.
- `m_axis_tvalid`, out, 1: head entry valid.
- `m_axis_tready`, in, 1: consumer accepts.

Status:
- `occupancy`, out, `$clog2(DEPTH)+1`: entries currently stored.
- `err`, out, 2: sticky error bits. bit0 = issue overrun, bit1 = unexpected result.

## Operation

**Counters**
- `inflight` counts launched operands whose results have not yet arrived.
- `occ` counts stored entries.
- Available credits are `DEPTH - occ - inflight`.
- `issue_ready` is 1 when credits > 0.

**Issue accounting**
- An issue is accepted when `issue_fire` is high and `issue_ready` is high; `inflight` increments.
- `issue_fire` while `issue_ready` is low is ignored and sets `err[0]`.

**Result arrival**
- On `s_axis_result_tvalid`, the result is written at the write pointer, `occ` increments and `inflight` decrements.
- If `inflight` is 0 when a result arrives, the result is still stored if a slot is free, and `err[1]` is set.
- If the buffer is full and no read happens in the same cycle, the word is dropped and `err[1]` is set.

**Read**
- A read occurs when `m_axis_tvalid` and `m_axis_tready` are both high. The read pointer advances and `occ` decrements.

**Simultaneous events**
- An accepted issue and a result arrival in the same cycle leave `inflight` unchanged.
- A write and a read in the same cycle leave `occ` unchanged. This is legal when full.
- A read frees its slot for a same-cycle write, so a write while full with a concurrent read is not an error.

**Storage and pointers**
- Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Storage is a register array. The head is presented first-word-fall-through.

**Errors**
- `err` bits are sticky until reset.

## Timing

**Reset values** (while `aresetn` is high and on release)
- `issue_ready`=0. It rises the first cycle after release.
- `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tflag`=0.
- `occupancy`=0, `err`=0, both pointers 0, `inflight`=0.

**Latency and handshake**
- Result write to `m_axis_tvalid` high: 1 cycle. The data is registered; there is no combinational path from the result side to the consumer side.
- `issue_ready` is registered from the next-state counters. A credit freed by a read at edge N is visible as `issue_ready` after edge N.
- `m_axis_tdata` and `m_axis_tflag` hold stable while `tvalid` is high and `tready` is low.
- `m_axis_tvalid` deasserts only after a read that leaves the buffer empty.

**Reset mid-operation**
- All contents and in-flight accounting are discarded.
- Results arriving in the first cycle after release count as unexpected and set `err[1]`.

## Configuration

**`FPU_RESULT_FIFO_FLAG_EN`**
- Defined: the 3 flag bits are stored per entry and presented on `m_axis_tflag`.
- Undefined: flag storage is removed, `s_flag` is unused, and `m_axis_tflag` is tied to 0.

## Structure

**Shared package `fpu_pkg`**
- `EXP` and `FRA` defaults.
- Flag bit indices: `FLAG_ZERO`=0, `FLAG_INF`=1, `FLAG_NAN`=2.
- Result word typedef.

**Sub-module `fpu_credit_ctr`**
- Holds the `inflight` and credit arithmetic, and produces `issue_ready` and `err[0]`.

**Top level**
- Holds storage, pointers and the consumer handshake.

## Test plan

1. **Reset and fill:** after reset, launch 8 issues back-to-back. Expect `issue_ready` to fall after the 8th accepted issue, and a 9th `issue_fire` to set `err[0]`.
2. **Stall with ordering:** with `tready`=0, deliver results 0x3C00 and 0x4000. Expect `tvalid` high one cycle after the first arrival and `tdata` held at 0x3C00. Then raise `tready`: expect 0x3C00 then 0x4000 in order, then `tvalid` low.
3. **Full with simultaneous read/write:** with `occ`=8, a read and a result write in the same cycle. Expect `occ` to stay at 8, no error, and the new word to appear last.
4. **Unexpected result:** with `inflight`=0, deliver one result. Expect the word stored, `occupancy`=1, and `err[1]` set.
5. **Wrap-around:** stream 20 results through at full throughput with `tready`=1 and issues paced by credits. Expect all 20 words out in order with no errors and `occupancy` returning to 0.
6. **Flag pass-through:** with the macro defined, deliver `s_flag`=3'b100. Expect `m_axis_tflag`=3'b100 with its word. With the macro undefined, expect `m_axis_tflag`=0.
